move_command_gen: RTL and testbench
===================================

// Module: move_command_gen
// PURPOSE
// Turns four raw active-high direction buttons into the single-cycle up/down/left/right move
// pulses consumed by the cursor position tracker. Synchronises and debounces each button,
// selects one direction by priority, emits one pulse per press plus typematic auto-repeat
// while held. Sits between board key inputs and the cursor position logic.
// PARAMETERS
// DEBOUNCE_CYCLES  500000    consecutive stable cycles before a key's debounced state changes (>=1)
// REPEAT_DELAY     25000000  cycles from first pulse to first repeat pulse (>=1)
// REPEAT_PERIOD    5000000   cycles between subsequent repeat pulses (>=1)
// REPEAT_EN        1         1: auto-repeat while held; 0: one pulse per press only
// PORTS
// CLOCK_50   in   1  system clock; all logic on posedge
// reset      in   1  synchronous, active-high reset
// key_up     in   1  raw button, asynchronous, may bounce
// key_down   in   1  raw button, asynchronous, may bounce
// key_left   in   1  raw button, asynchronous, may bounce
// key_right  in   1  raw button, asynchronous, may bounce
// up         out  1  registered move pulse, one cycle wide
// down       out  1  registered move pulse, one cycle wide
// left       out  1  registered move pulse, one cycle wide
// right      out  1  registered move pulse, one cycle wide
// key_held   out  1  registered; 1 while any debounced key is pressed
// BEHAVIOUR
// - Reset: sync flops, debounced states, debounce counters, repeat counter all 0; FSM IDLE;
//   up/down/left/right/key_held = 0. Reset mid-hold aborts everything; a key still held after
//   reset release is a fresh press (pulse DEBOUNCE_CYCLES+3 edges after reset deasserts).
// - Sync: each key through 2-flop synchroniser.
// - Debounce per key: counter increments each cycle sync!=db, clears when sync==db; on the edge
//   where it would reach DEBOUNCE_CYCLES, db takes sync value and counter clears. Glitches
//   shorter than DEBOUNCE_CYCLES never change db. Counter width $clog2(DEBOUNCE_CYCLES+1).
// - Selection: sel = highest-priority debounced-pressed key, up > down > right > left; NONE if none.
// - Mutual exclusion: at most one of up/down/left/right is 1 in any cycle.
// - FSM (registered sel_q holds last selected direction):
//   IDLE:   sel!=NONE -> pulse sel, sel_q<=sel, rpt_cnt<=0, go DELAY (REPEAT_EN=0: go HOLD).
//   DELAY:  sel==NONE -> IDLE, no pulse. sel!=sel_q -> pulse sel, restart DELAY.
//           else rpt_cnt++; when rpt_cnt==REPEAT_DELAY-1 -> pulse sel_q, rpt_cnt<=0, go REPEAT.
//   REPEAT: same NONE/change rules as DELAY; rpt_cnt==REPEAT_PERIOD-1 -> pulse, rpt_cnt<=0, stay.
//   HOLD:   sel==NONE -> IDLE; sel!=sel_q -> pulse sel, stay HOLD; else no pulse.
// - Timing: raw key rising and stable -> pulse high DEBOUNCE_CYCLES+3 edges later. With first
//   pulse at cycle t0 and key held: repeats at t0+REPEAT_DELAY, then every REPEAT_PERIOD.
// - Simultaneous presses debounced in the same cycle: only the higher-priority direction pulses.
//   Releasing the active key while a lower-priority key is held: lower key pulses immediately,
//   DELAY restarts. Pressing a higher-priority key while one is held: it pulses immediately.
// - rpt_cnt width $clog2(max(REPEAT_DELAY,REPEAT_PERIOD)+1); never wraps (cleared at terminal).
// - key_held = |debounced states, registered (one cycle after db change).
// TESTING (DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=5, REPEAT_EN=1 unless noted)
// 1 Reset, key_up high at cycle 0 held 40 cycles -> up pulses at cycle 7, 17, 22, 27, 32, ...;
//   no other output ever high; key_held high from cycle 7.
// 2 key_right toggles every 2 cycles for 20 cycles then low -> no pulse, key_held stays 0.
// 3 key_left and key_down rise same cycle, held -> only down pulses; release key_down ->
//   left pulses 7 edges after release (debounce+sync), then repeats 10 later.
// 4 REPEAT_EN=0, key_up held 50 cycles -> exactly one up pulse; release then press -> one more.
// 5 key_down held, assert reset 1 cycle at cycle 15 while held -> all outputs 0 during/after reset;
//   down pulse 7 edges after reset deasserts, repeat schedule restarts from that pulse.
// 6 Held key_left, press key_up at repeat-pulse boundary -> up pulses alone; no cycle has two pulses.

Source files
------------

// File: rtl/move_command_gen.sv
`default_nettype none
// ============================================================================
// move_command_gen : four raw direction buttons -> synchronised, debounced,
//                    prioritised single-cycle move pulses with auto-repeat.
// Revision: 1.0  initial release
// ============================================================================
module move_command_gen #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000,
  parameter bit REPEAT_EN       = 1'b1
) (
  input  logic CLOCK_50,
  input  logic reset,
  input  logic key_up,
  input  logic key_down,
  input  logic key_left,
  input  logic key_right,
  output logic up,
  output logic down,
  output logic left,
  output logic right,
  output logic key_held
);

  localparam int DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RPT_W   = $clog2(RPT_MAX + 1);

  localparam logic [DB_W-1:0]  DB_LAST     = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [RPT_W-1:0] DELAY_LAST  = RPT_W'(REPEAT_DELAY - 1);
  localparam logic [RPT_W-1:0] PERIOD_LAST = RPT_W'(REPEAT_PERIOD - 1);
  localparam logic [DB_W-1:0]  DB_ONE      = DB_W'(1);
  localparam logic [RPT_W-1:0] RPT_ONE     = RPT_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DELAY  = 2'd1,
    ST_REPEAT = 2'd2,
    ST_HOLD   = 2'd3
  } state_t;

  // Bit order is the priority order: bit 0 (up) beats down, then right, then left.
  logic [3:0] raw;
  logic [3:0] sync1;
  logic [3:0] sync2;
  logic [3:0] db;
  logic [DB_W-1:0] db_cnt [4];
  logic [3:0] sel_oh;
  logic [3:0] sel_q;
  logic [3:0] moves;
  logic [RPT_W-1:0] rpt_cnt;
  logic [RPT_W-1:0] rpt_last;
  state_t state;

  assign raw = {key_left, key_right, key_down, key_up};

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      db <= '0;
      for (int i = 0; i < 4; i++) db_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (sync2[i] == db[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          db[i]     <= sync2[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + DB_ONE;
        end
      end
    end
  end

  // Isolate the lowest set bit: the highest-priority pressed key, zero if none.
  assign sel_oh   = db & (~db + 4'd1);
  assign rpt_last = (state == ST_DELAY) ? DELAY_LAST : PERIOD_LAST;

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state    <= ST_IDLE;
      sel_q    <= '0;
      rpt_cnt  <= '0;
      moves    <= '0;
      key_held <= 1'b0;
    end else begin
      moves    <= '0;
      key_held <= |db;
      case (state)
        ST_IDLE: begin
          if (sel_oh != 4'd0) begin
            moves   <= sel_oh;
            sel_q   <= sel_oh;
            rpt_cnt <= '0;
            state   <= REPEAT_EN ? ST_DELAY : ST_HOLD;
          end
        end
        ST_DELAY, ST_REPEAT: begin
          if (sel_oh == 4'd0) begin
            state   <= ST_IDLE;
            rpt_cnt <= '0;
          end else if (sel_oh != sel_q) begin
            moves   <= sel_oh;
            sel_q   <= sel_oh;
            rpt_cnt <= '0;
            state   <= ST_DELAY;
          end else if (rpt_cnt == rpt_last) begin
            moves   <= sel_q;
            rpt_cnt <= '0;
            state   <= ST_REPEAT;
          end else begin
            rpt_cnt <= rpt_cnt + RPT_ONE;
          end
        end
        ST_HOLD: begin
          if (sel_oh == 4'd0) begin
            state <= ST_IDLE;
          end else if (sel_oh != sel_q) begin
            moves <= sel_oh;
            sel_q <= sel_oh;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign up    = moves[0];
  assign down  = moves[1];
  assign right = moves[2];
  assign left  = moves[3];

endmodule
`default_nettype wire

// File: tb/tb_move_command_gen.sv
`default_nettype none
// Bench for move_command_gen: directed table and sequences plus random presses,
// checked against a timestamp-based model of the move-pulse rules.
module tb_move_command_gen;

  localparam int D  = 4;
  localparam int RD = 10;
  localparam int RP = 5;

  typedef struct {
    int c;
    bit up;
    bit held;
  } vec_t;

  logic       clk  = 1'b0;
  logic       rst  = 1'b1;
  logic [3:0] keys = 4'b0000;   // bit0 up, bit1 down, bit2 right, bit3 left
  logic up0, down0, left0, right0, held0;
  logic up1, down1, left1, right1, held1;
  logic [3:0] mv0, mv1;

  assign mv0 = {left0, right0, down0, up0};
  assign mv1 = {left1, right1, down1, up1};

  move_command_gen #(.DEBOUNCE_CYCLES(D), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP), .REPEAT_EN(1'b1)) dut (
    .CLOCK_50(clk), .reset(rst),
    .key_up(keys[0]), .key_down(keys[1]), .key_left(keys[3]), .key_right(keys[2]),
    .up(up0), .down(down0), .left(left0), .right(right0), .key_held(held0));

  move_command_gen #(.DEBOUNCE_CYCLES(D), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP), .REPEAT_EN(1'b0)) dut_nr (
    .CLOCK_50(clk), .reset(rst),
    .key_up(keys[0]), .key_down(keys[1]), .key_left(keys[3]), .key_right(keys[2]),
    .up(up1), .down(down1), .left(left1), .right(right1), .key_held(held1));

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Model state: raw/sync history per key, debounced levels, and per instance
  // the active direction with the timestamp of its last pulse.
  logic [3:0] r1 = '0, s = '0, db = '0;
  bit         hist [4][$];
  int         active [2];
  int         anchor [2];
  bit         first  [2];
  logic [3:0] exp_mv [2];
  bit         exp_held;

  task automatic model_edge();
    logic [3:0] nd;
    int sel, el;
    bit flip;
    if (rst) begin
      r1 = '0; s = '0; db = '0;
      for (int k = 0; k < 4; k++) hist[k].delete();
      for (int m = 0; m < 2; m++) begin active[m] = -1; exp_mv[m] = '0; end
      exp_held = 1'b0;
    end else begin
      sel = -1;
      for (int k = 3; k >= 0; k--) if (db[k]) sel = k;
      for (int m = 0; m < 2; m++) begin
        exp_mv[m] = '0;
        if (sel < 0) begin
          active[m] = -1;
        end else if (sel != active[m]) begin
          exp_mv[m][sel] = 1'b1;
          active[m] = sel; anchor[m] = cyc; first[m] = 1'b1;
        end else if (m == 0) begin
          el = cyc - anchor[m];
          if (el == (first[m] ? RD : RP)) begin
            exp_mv[m][sel] = 1'b1;
            anchor[m] = cyc; first[m] = 1'b0;
          end
        end
      end
      exp_held = |db;
      nd = db;
      // A key's level flips once the last D synchronised samples all disagree with it.
      for (int k = 0; k < 4; k++) begin
        hist[k].push_back(s[k]);
        if (hist[k].size() > D) void'(hist[k].pop_front());
        if (hist[k].size() == D) begin
          flip = 1'b1;
          for (int j = 0; j < hist[k].size(); j++) if (hist[k][j] == db[k]) flip = 1'b0;
          if (flip) nd[k] = ~db[k];
        end
      end
      s = r1; r1 = keys; db = nd;
    end
    cyc++;
  endtask

  task automatic check_model();
    total++;
    if (mv0 !== exp_mv[0] || held0 !== exp_held) begin
      bad++;
      $display("FAIL model_rpt cyc=%0d got mv=%b held=%b want mv=%b held=%b", cyc, mv0, held0, exp_mv[0], exp_held);
    end
    total++;
    if (mv1 !== exp_mv[1] || held1 !== exp_held) begin
      bad++;
      $display("FAIL model_norpt cyc=%0d got mv=%b held=%b want mv=%b held=%b", cyc, mv1, held1, exp_mv[1], exp_held);
    end
    total++;
    if ($countones(mv0) > 1 || $countones(mv1) > 1) begin
      bad++;
      $display("FAIL exclusive cyc=%0d got mv0=%b mv1=%b want at most one bit each", cyc, mv0, mv1);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_model();
  endtask

  task automatic expect_int(input string name, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask

  // Steps until dut pulses direction dir; n = edges taken, or -1 on timeout.
  task automatic wait_pulse(input int dir, input int maxc, output int n);
    n = -1;
    for (int i = 1; i <= maxc; i++) begin
      step();
      if (mv0[dir]) begin n = i; break; end
    end
  endtask

  task automatic idle(input int n);
    keys = 4'b0000;
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    vec_t tbl [11];
    int n, cnt_d, cnt_l, cnt_nr, len;
    bit any_held, any_pulse;

    tbl = '{'{6, 1'b0, 1'b0}, '{7, 1'b1, 1'b1}, '{8, 1'b0, 1'b1}, '{16, 1'b0, 1'b1},
            '{17, 1'b1, 1'b1}, '{18, 1'b0, 1'b1}, '{22, 1'b1, 1'b1}, '{26, 1'b0, 1'b1},
            '{27, 1'b1, 1'b1}, '{32, 1'b1, 1'b1}, '{37, 1'b1, 1'b1}};

    // Reset, then key_up held from cycle 0
    rst = 1'b1; keys = 4'b0000;
    step(); step();
    rst = 1'b0; keys = 4'b0001;
    cnt_nr = 0;
    for (int k = 1; k <= 50; k++) begin
      step();
      if (up1) cnt_nr++;
      for (int j = 0; j < 11; j++) begin
        if (tbl[j].c == k) begin
          total++;
          if (up0 !== tbl[j].up || held0 !== tbl[j].held || {left0, right0, down0} !== 3'b000) begin
            bad++;
            $display("FAIL table_up cyc=%0d got up=%b held=%b others=%b want up=%b held=%b others=000",
                     k, up0, held0, {left0, right0, down0}, tbl[j].up, tbl[j].held);
          end
        end
      end
    end
    expect_int("norpt_single_pulse", cnt_nr, 1);
    idle(10);
    keys = 4'b0001; cnt_nr = 0;
    for (int k = 0; k < 20; k++) begin step(); if (up1) cnt_nr++; end
    expect_int("norpt_repress_pulse", cnt_nr, 1);
    idle(12);

    // Bouncing right key shorter than the debounce window
    any_held = 1'b0; any_pulse = 1'b0;
    for (int k = 0; k < 20; k++) begin
      keys = {1'b0, ((k / 2) % 2) == 1, 2'b00};
      step();
      any_held  |= held0;
      any_pulse |= |mv0;
    end
    idle(10);
    expect_int("bounce_held", int'(any_held), 0);
    expect_int("bounce_pulse", int'(any_pulse), 0);

    // Down and left together: down wins; releasing down hands over to left
    keys = 4'b1010; cnt_d = 0; cnt_l = 0;
    for (int k = 0; k < 25; k++) begin
      step();
      if (down0) cnt_d++;
      if (left0) cnt_l++;
    end
    expect_int("simul_down_pulses", cnt_d, 3);
    expect_int("simul_left_pulses", cnt_l, 0);
    keys = 4'b1000;
    wait_pulse(3, 20, n);
    expect_int("handover_left_latency", n, 7);
    wait_pulse(3, 20, n);
    expect_int("handover_left_repeat", n, RD);
    idle(12);

    // Reset while down is held restarts everything
    keys = 4'b0010;
    for (int k = 0; k < 15; k++) step();
    rst = 1'b1;
    step();
    expect_int("reset_outputs", int'({mv0, held0, mv1, held1}), 0);
    rst = 1'b0;
    wait_pulse(1, 20, n);
    expect_int("post_reset_latency", n, 7);
    wait_pulse(1, 20, n);
    expect_int("post_reset_repeat", n, RD);
    idle(12);

    // Up pressed on a left repeat-pulse boundary
    keys = 4'b1000;
    wait_pulse(3, 20, n);
    wait_pulse(3, 20, n);
    expect_int("boundary_left_repeat", n, RD);
    keys = 4'b1001;
    wait_pulse(0, 20, n);
    expect_int("boundary_up_latency", n, 7);
    idle(12);

    // Random presses, glitches and occasional resets
    for (int seg = 0; seg < 150; seg++) begin
      if ($urandom_range(0, 40) == 0) begin
        rst = 1'b1; step(); rst = 1'b0;
      end
      keys = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) keys = 4'b0000;
      len = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : int'($urandom_range(5, 30));
      for (int i = 0; i < len; i++) step();
    end
    idle(10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
